// File: rtl/reaction_timer_pkg.sv
// Shared types, constants and helpers for the reaction-time game datapath.
// Imported by the interface, the BCD counter and the top level.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_DONE,
        ST_FOUL
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int          DELAY_W    = 16;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam bcd_t        FOUL_DIGIT = 4'hF;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

    // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1 in right-shift form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // States in which a start press begins a new round.
    function automatic logic is_armable(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FOUL);
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Button inputs and display/status outputs of the reaction timer.
// The game logic uses the slave side; the board wrapper or bench uses master.
interface reaction_timer_if;
    import reaction_timer_pkg::*;

    logic start;
    logic stop;
    logic led;
    bcd_t digit3;
    bcd_t digit2;
    bcd_t digit1;
    bcd_t digit0;
    logic foul;
    logic overflow;
    logic busy;

    modport master (
        output start, stop,
        input  led, digit3, digit2, digit1, digit0, foul, overflow, busy
    );

    modport slave (
        input  start, stop,
        output led, digit3, digit2, digit1, digit0, foul, overflow, busy
    );

endinterface

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, ripple carry and
// saturation at 9999; reusable by later score stages.
module bcd_counter4
    import reaction_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] digits,
    output logic        sat
);

    logic [15:0] digits_q;
    logic [15:0] digits_d;
    logic        carry;

    assign sat    = (digits_q == BCD_MAX);
    assign digits = digits_q;

    always_comb begin
        digits_d = digits_q;
        carry    = 1'b0;
        if (clr) begin
            digits_d = '0;
        end else if (inc && !sat) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (digits_q[i*4 +: 4] == 4'd9) begin
                        digits_d[i*4 +: 4] = 4'd0;
                    end else begin
                        digits_d[i*4 +: 4] = digits_q[i*4 +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random pre-stimulus delay, LED stimulus,
// millisecond BCD measurement until the stop press, foul and overflow flags.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_EN      = 1
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    reaction_timer_if.slave  io
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

    logic [2:0]         start_sync_q, start_sync_d;
    logic [2:0]         stop_sync_q, stop_sync_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PW-1:0]      presc_q, presc_d;

    logic               start_ev;
    logic               stop_ev;
    logic               tick;
    logic               arm;
    logic [DELAY_W-1:0] delay_load;

    state_t             state_q;
    logic               led_q;
    logic               foul_q;
    logic               ovf_q;
    logic               busy_q;
    logic [DELAY_W-1:0] delay_q;

    logic               cnt_clr;
    logic               cnt_inc;
    logic               cnt_sat;
    logic [15:0]        cnt_digits;

    // Bit 0/1 are the synchronizer, bit 2 remembers the previous level.
    assign start_ev = start_sync_q[1] & ~start_sync_q[2];
    assign stop_ev  = stop_sync_q[1] & ~stop_sync_q[2];
    assign tick     = (presc_q == TICK_LAST);
    assign arm      = start_ev && is_armable(state_q);

    assign delay_load = DELAY_W'(MIN_DELAY_MS)
                      + ((RAND_EN != 0) ? DELAY_W'(lfsr_q[10:0]) : '0);

    always_comb begin
        start_sync_d = {start_sync_q[1:0], io.start};
        stop_sync_d  = {stop_sync_q[1:0], io.stop};
        lfsr_d       = lfsr_next(lfsr_q);
        // RUN is only ever entered on a tick, so the wrap already restarts it.
        presc_d      = (tick || arm) ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            start_sync_q <= '0;
            stop_sync_q  <= '0;
            lfsr_q       <= LFSR_SEED;
            presc_q      <= '0;
        end else begin
            start_sync_q <= start_sync_d;
            stop_sync_q  <= stop_sync_d;
            lfsr_q       <= lfsr_d;
            presc_q      <= presc_d;
        end
    end

    assign cnt_clr = arm;
    assign cnt_inc = (state_q == ST_RUN) && tick;

    bcd_counter4 u_count (
        .clk    (CLOCK_50),
        .rst_n  (RST_N),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .digits (cnt_digits),
        .sat    (cnt_sat)
    );

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            led_q   <= 1'b0;
            foul_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            delay_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FOUL: begin
                    if (start_ev) begin
                        state_q <= ST_WAIT;
                        delay_q <= delay_load;
                        led_q   <= 1'b0;
                        foul_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A stop on the expiry tick is still a foul.
                    if (stop_ev) begin
                        state_q <= ST_FOUL;
                        foul_q  <= 1'b1;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        delay_q <= delay_q - 1'b1;
                        if (delay_q <= DELAY_W'(1)) begin
                            state_q <= ST_RUN;
                            led_q   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if ((tick && cnt_sat) || stop_ev) begin
                        state_q <= ST_DONE;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    if (tick && cnt_sat) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io.led      = led_q;
    assign io.foul     = foul_q;
    assign io.overflow = ovf_q;
    assign io.busy     = busy_q;
    assign io.digit3   = foul_q ? FOUL_DIGIT : cnt_digits[15:12];
    assign io.digit2   = foul_q ? FOUL_DIGIT : cnt_digits[11:8];
    assign io.digit1   = foul_q ? FOUL_DIGIT : cnt_digits[7:4];
    assign io.digit0   = foul_q ? FOUL_DIGIT : cnt_digits[3:0];

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: three instances (TICK_DIV=4 fixed delay, TICK_DIV=1,
// TICK_DIV=4 random delay) checked every cycle against a millisecond-level model.
module tb_reaction_timer;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;
    localparam int P_FOUL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic start_in [3];
    logic stop_in  [3];

    logic        o_led  [3];
    logic        o_foul [3];
    logic        o_ovf  [3];
    logic        o_busy [3];
    logic [15:0] o_dig  [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    reaction_timer_if ifa ();
    reaction_timer_if ifb ();
    reaction_timer_if ifc ();

    assign ifa.start = start_in[0];
    assign ifa.stop  = stop_in[0];
    assign ifb.start = start_in[1];
    assign ifb.stop  = stop_in[1];
    assign ifc.start = start_in[2];
    assign ifc.stop  = stop_in[2];

    assign o_led[0]  = ifa.led;
    assign o_foul[0] = ifa.foul;
    assign o_ovf[0]  = ifa.overflow;
    assign o_busy[0] = ifa.busy;
    assign o_dig[0]  = {ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0};
    assign o_led[1]  = ifb.led;
    assign o_foul[1] = ifb.foul;
    assign o_ovf[1]  = ifb.overflow;
    assign o_busy[1] = ifb.busy;
    assign o_dig[1]  = {ifb.digit3, ifb.digit2, ifb.digit1, ifb.digit0};
    assign o_led[2]  = ifc.led;
    assign o_foul[2] = ifc.foul;
    assign o_ovf[2]  = ifc.overflow;
    assign o_busy[2] = ifc.busy;
    assign o_dig[2]  = {ifc.digit3, ifc.digit2, ifc.digit1, ifc.digit0};

    reaction_timer #(.TICK_DIV(4), .MIN_DELAY_MS(3), .RAND_EN(0)) dut_a (
        .CLOCK_50(clk), .RST_N(rst_a), .io(ifa));
    reaction_timer #(.TICK_DIV(1), .MIN_DELAY_MS(3), .RAND_EN(0)) dut_b (
        .CLOCK_50(clk), .RST_N(rst_b), .io(ifb));
    reaction_timer #(.TICK_DIV(4), .MIN_DELAY_MS(3), .RAND_EN(1)) dut_c (
        .CLOCK_50(clk), .RST_N(rst_c), .io(ifc));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase [3];
    int          m_wait  [3];
    int          m_run   [3];
    int          m_cnt   [3];
    bit          m_led   [3];
    bit          m_foul  [3];
    bit          m_ovf   [3];
    logic [15:0] m_lfsr  [3];
    logic [3:0]  m_hs    [3];
    logic [3:0]  m_hp    [3];

    function automatic int td_of(input int i);
        return (i == 1) ? 1 : 4;
    endfunction

    function automatic logic rst_of(input int i);
        return (i == 0) ? rst_a : (i == 1) ? rst_b : rst_c;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic m_reset(input int i);
        m_phase[i] = P_IDLE;
        m_wait[i]  = 0;
        m_run[i]   = 0;
        m_cnt[i]   = 0;
        m_led[i]   = 1'b0;
        m_foul[i]  = 1'b0;
        m_ovf[i]   = 1'b0;
        m_lfsr[i]  = 16'hACE1;
        m_hs[i]    = 4'b0;
        m_hp[i]    = 4'b0;
    endtask

    task automatic m_step(input int i);
        bit se, pe;
        int d;
        // A button acts two edges after it is first sampled high.
        se = m_hs[i][1] && !m_hs[i][2];
        pe = m_hp[i][1] && !m_hp[i][2];
        m_hs[i] = {m_hs[i][2:0], start_in[i]};
        m_hp[i] = {m_hp[i][2:0], stop_in[i]};
        case (m_phase[i])
            P_WAIT: begin
                if (pe) begin
                    m_phase[i] = P_FOUL; m_foul[i] = 1'b1; m_led[i] = 1'b0;
                end else begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) begin
                        m_phase[i] = P_RUN; m_led[i] = 1'b1; m_run[i] = 0;
                    end
                end
            end
            P_RUN: begin
                m_run[i]++;
                if (m_run[i] % td_of(i) == 0) begin
                    if (m_cnt[i] == 9999) begin
                        m_ovf[i] = 1'b1; m_led[i] = 1'b0; m_phase[i] = P_DONE;
                    end else begin
                        m_cnt[i]++;
                    end
                end
                if (pe) begin
                    m_led[i] = 1'b0; m_phase[i] = P_DONE;
                end
            end
            default: begin
                if (se) begin
                    d = 3 + ((i == 2) ? int'(m_lfsr[i][10:0]) : 0);
                    m_wait[i]  = d * td_of(i);
                    m_phase[i] = P_WAIT;
                    m_cnt[i]   = 0;
                    m_foul[i]  = 1'b0;
                    m_ovf[i]   = 1'b0;
                    m_led[i]   = 1'b0;
                end
            end
        endcase
        m_lfsr[i] = {m_lfsr[i][0] ^ m_lfsr[i][2] ^ m_lfsr[i][3] ^ m_lfsr[i][5], m_lfsr[i][15:1]};
    endtask

    // Resets are only asserted while clk is low, so clk==1 marks a clock edge.
    always @(posedge clk or negedge rst_a or negedge rst_b or negedge rst_c) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_of(i)) m_reset(i);
            else if (clk) m_step(i);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("led[%0d]", i), 32'(o_led[i]), 32'(m_led[i]));
                chk($sformatf("foul[%0d]", i), 32'(o_foul[i]), 32'(m_foul[i]));
                chk($sformatf("overflow[%0d]", i), 32'(o_ovf[i]), 32'(m_ovf[i]));
                chk($sformatf("busy[%0d]", i), 32'(o_busy[i]),
                    32'(m_phase[i] == P_WAIT || m_phase[i] == P_RUN));
                chk($sformatf("digits[%0d]", i), 32'(o_dig[i]),
                    32'(m_foul[i] ? 16'hFFFF : to_bcd(m_cnt[i])));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic press_start(input int i);
        start_in[i] = 1'b1;
        repeat (2) @(negedge clk);
        start_in[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_stop(input int i);
        stop_in[i] = 1'b1;
        repeat (2) @(negedge clk);
        stop_in[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_led(input int i, input logic lvl, input int bound, output int n);
        n = 0;
        while (o_led[i] !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_in[i] = 1'b0;
            stop_in[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset_led", 32'(o_led[0]), 0);
        chk("reset_busy", 32'(o_busy[0]), 0);
        chk("reset_foul", 32'(o_foul[0]), 0);
        chk("reset_ovf", 32'(o_ovf[0]), 0);
        chk("reset_digits", 32'(o_dig[0]), 0);
        rst_a = 1'b1; rst_b = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Normal round: 27 ms measured.
        start_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_before_3rd_edge", 32'(o_busy[0]), 0);
        start_in[0] = 1'b0;
        @(negedge clk);
        chk("busy_on_3rd_edge", 32'(o_busy[0]), 1);
        wait_led(0, 1'b1, 50, n);
        chk("led_delay_cycles", n, 12);
        repeat (107) @(negedge clk);
        stop_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("led_before_stop_acts", 32'(o_led[0]), 1);
        stop_in[0] = 1'b0;
        @(negedge clk);
        chk("led_after_stop", 32'(o_led[0]), 0);
        chk("result_0027", 32'(o_dig[0]), 32'h0027);

        // Foul during WAIT, then a fresh start.
        press_start(0);
        press_stop(0);
        chk("foul_flag", 32'(o_foul[0]), 1);
        chk("foul_digits", 32'(o_dig[0]), 32'hFFFF);
        repeat (20) @(negedge clk);
        chk("led_stays_off_after_foul", 32'(o_led[0]), 0);
        press_start(0);
        chk("restart_digits", 32'(o_dig[0]), 0);
        chk("restart_foul", 32'(o_foul[0]), 0);
        chk("restart_busy", 32'(o_busy[0]), 1);

        // Stop lands on the tick that takes 0099 to 0100.
        wait_led(0, 1'b1, 50, n);
        chk("led_delay_cycles_2", n, 12);
        repeat (397) @(negedge clk);
        press_stop(0);
        chk("result_0100", 32'(o_dig[0]), 32'h0100);
        chk("led_off_0100", 32'(o_led[0]), 0);

        // Asynchronous reset mid-RUN.
        press_start(0);
        wait_led(0, 1'b1, 50, n);
        repeat (30) @(negedge clk);
        chk("led_on_before_reset", 32'(o_led[0]), 1);
        chk("digits_before_reset", 32'(o_dig[0]), 32'h0007);
        #2 rst_a = 1'b0;
        #1;
        chk("async_reset_led", 32'(o_led[0]), 0);
        chk("async_reset_digits", 32'(o_dig[0]), 0);
        chk("async_reset_busy", 32'(o_busy[0]), 0);
        @(negedge clk);
        rst_a = 1'b1;

        // Overflow with one tick per cycle.
        press_start(1);
        n = 0;
        while (o_busy[1] !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("overflow_reached_in_budget", 32'(n < 20000), 1);
        chk("overflow_digits", 32'(o_dig[1]), 32'h9999);
        chk("overflow_flag", 32'(o_ovf[1]), 1);
        chk("overflow_led", 32'(o_led[1]), 0);
        repeat (100) @(negedge clk);
        chk("overflow_digits_hold", 32'(o_dig[1]), 32'h9999);
        chk("overflow_flag_hold", 32'(o_ovf[1]), 1);
        chk("overflow_busy_hold", 32'(o_busy[1]), 0);

        // Random delay: start acts on the 3rd edge after reset release,
        // when the LFSR holds 0xAB38 -> 3 + 0x338 = 827 ms = 3308 cycles.
        rst_c = 1'b1;
        start_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        start_in[2] = 1'b0;
        @(negedge clk);
        chk("rand_busy", 32'(o_busy[2]), 1);
        wait_led(2, 1'b1, 5000, n);
        chk("rand_delay_cycles", n, 3308);

        repeat (5) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
